// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Redirect beats halt beats stall; HALT is left only through reset.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemData,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [31:0] ifidInstr,
   output logic [31:0] ifidPC,
   output logic        ifidValid,
   output logic [6:0]  opCode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        halted,
   output logic [31:0] fetchCount
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      ifid_pc_d = ifid_pc_q;
      valid_d   = valid_q;
      count_d   = count_q;
      if (state_q == RUN) begin
         if (branchTaken) begin
            pc_d      = {branchTarget[31:2], 2'b00};
            instr_d   = NOP_INSTR;
            ifid_pc_d = '0;
            valid_d   = 1'b0;
         end else if (halt && valid_q) begin
            // a halt decoded from a bubble is never honoured
            state_d   = HALT;
            instr_d   = NOP_INSTR;
            ifid_pc_d = '0;
            valid_d   = 1'b0;
         end else if (!stall) begin
            instr_d   = imemData;
            ifid_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
            count_d   = (count_q == '1) ? count_q : count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         ifid_pc_q <= '0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         ifid_pc_q <= ifid_pc_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   assign pc         = pc_q;
   assign imemAddr   = pc_q;
   assign ifidInstr  = instr_q;
   assign ifidPC     = ifid_pc_q;
   assign ifidValid  = valid_q;
   assign halted     = (state_q == HALT);
   assign fetchCount = count_q;

   assign opCode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign rd     = instr_q[11:7];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, PC wrap instance, random run against a model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset, stall, branchTaken, halt;
   logic [31:0] branchTarget;

   logic [31:0] imemAddr, imemData, pc, ifidInstr, ifidPC, fetchCount;
   logic        ifidValid, halted;
   logic [6:0]  opCode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;

   logic [31:0] w_imemAddr, w_imemData, w_pc, w_ifidInstr, w_ifidPC, w_fetchCount;
   logic        w_ifidValid, w_halted;
   logic [6:0]  w_opCode, w_funct7;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rs1, w_rs2, w_rd;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imemData   = mem_word(imemAddr);
   assign w_imemData = mem_word(w_imemAddr);

   instruction_fetch u_dut (
      .clk(clk), .reset(reset), .imemAddr(imemAddr), .imemData(imemData),
      .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
      .halt(halt), .pc(pc), .ifidInstr(ifidInstr), .ifidPC(ifidPC),
      .ifidValid(ifidValid), .opCode(opCode), .funct3(funct3), .funct7(funct7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .halted(halted), .fetchCount(fetchCount)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .reset(reset), .imemAddr(w_imemAddr), .imemData(w_imemData),
      .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
      .halt(halt), .pc(w_pc), .ifidInstr(w_ifidInstr), .ifidPC(w_ifidPC),
      .ifidValid(w_ifidValid), .opCode(w_opCode), .funct3(w_funct3), .funct7(w_funct7),
      .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .halted(w_halted), .fetchCount(w_fetchCount)
   );

   typedef struct {
      logic        rst_n, stl, br;
      logic [31:0] tgt;
      logic        hlt;
      logic [31:0] e_pc, e_ifpc;
      logic        e_v, e_h;
      logic [31:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc, ifpc, instr, cnt;
      logic        v, h;
   } model_t;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
   endtask

   task automatic check_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                            input logic [31:0] e_instr, input logic e_v, input logic e_h,
                            input logic [31:0] e_cnt);
      chk("pc", idx, pc, e_pc);
      chk("imemAddr", idx, imemAddr, e_pc);
      chk("ifidInstr", idx, ifidInstr, e_instr);
      chk("ifidPC", idx, ifidPC, e_ifpc);
      chk("ifidValid", idx, {31'd0, ifidValid}, {31'd0, e_v});
      chk("halted", idx, {31'd0, halted}, {31'd0, e_h});
      chk("fetchCount", idx, fetchCount, e_cnt);
      chk("opCode", idx, {25'd0, opCode}, {25'd0, e_instr[6:0]});
      chk("funct3", idx, {29'd0, funct3}, {29'd0, e_instr[14:12]});
      chk("funct7", idx, {25'd0, funct7}, {25'd0, e_instr[31:25]});
      chk("rs1", idx, {27'd0, rs1}, {27'd0, e_instr[19:15]});
      chk("rs2", idx, {27'd0, rs2}, {27'd0, e_instr[24:20]});
      chk("rd", idx, {27'd0, rd}, {27'd0, e_instr[11:7]});
   endtask

   task automatic drive_step(input logic r, input logic s, input logic b,
                             input logic [31:0] t, input logic h);
      reset = r; stall = s; branchTaken = b; branchTarget = t; halt = h;
      @(posedge clk);
      #1;
   endtask

   // Reference: next state straight from the per-cycle priority rules.
   function automatic model_t model_next(input model_t m, input logic r, input logic s,
                                         input logic b, input logic [31:0] t, input logic h);
      model_t n = m;
      if (!r) begin
         n.pc = 32'h0; n.ifpc = 32'h0; n.instr = 32'h13; n.v = 1'b0; n.h = 1'b0; n.cnt = 32'h0;
      end else if (!m.h) begin
         if (b) begin
            n.pc = t & ~32'h3; n.ifpc = 32'h0; n.instr = 32'h13; n.v = 1'b0;
         end else if (h && m.v) begin
            n.h = 1'b1; n.ifpc = 32'h0; n.instr = 32'h13; n.v = 1'b0;
         end else if (!s) begin
            n.instr = mem_word(m.pc); n.ifpc = m.pc; n.v = 1'b1;
            n.pc = m.pc + 32'd4;
            if (m.cnt != 32'hFFFF_FFFF) n.cnt = m.cnt + 32'd1;
         end
      end
      return n;
   endfunction

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] t,
                               input logic h, input logic [31:0] epc, input logic [31:0] eifpc,
                               input logic ev, input logic eh, input logic [31:0] ecnt);
      vec_t x;
      x.rst_n = r; x.stl = s; x.br = b; x.tgt = t; x.hlt = h;
      x.e_pc = epc; x.e_ifpc = eifpc; x.e_v = ev; x.e_h = eh; x.e_cnt = ecnt;
      return x;
   endfunction

   initial begin
      model_t m;
      logic r, s, b, h;
      logic [31:0] t;

      reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; halt = 1'b0;

      //            rst  stl  br   tgt           hlt   pc            ifidPC        v    h    cnt
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0000_0000, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0004, 32'h0,        1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0008, 32'h4,        1, 0, 2));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_000C, 32'h8,        1, 0, 3));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0000_000C, 32'h8,        1, 0, 3));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0000_000C, 32'h8,        1, 0, 3));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0010, 32'hC,        1, 0, 4));
      vecs.push_back(mk(1, 0, 1, 32'h0000_0103, 0, 32'h0000_0100, 32'h0,        0, 0, 4));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0104, 32'h100,      1, 0, 5));
      vecs.push_back(mk(1, 1, 1, 32'h0000_0203, 1, 32'h0000_0200, 32'h0,        0, 0, 5));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0204, 32'h200,      1, 0, 6));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0204, 32'h0,        0, 1, 6));
      vecs.push_back(mk(1, 0, 1, 32'h0000_0040, 0, 32'h0000_0204, 32'h0,        0, 1, 6));
      vecs.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0000_0204, 32'h0,        0, 1, 6));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0000_0000, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0004, 32'h0,        1, 0, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0000_0008, 32'h4,        1, 0, 2));
      vecs.push_back(mk(0, 1, 1, 32'h0000_0500, 1, 32'h0000_0000, 32'h0,        0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 32'h0000_0802, 0, 32'h0000_0800, 32'h0,        0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0000_0000, 32'h0,        0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive_step(vecs[i].rst_n, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].hlt);
         check_all(i, vecs[i].e_pc, vecs[i].e_ifpc,
                   vecs[i].e_v ? mem_word(vecs[i].e_ifpc) : 32'h0000_0013,
                   vecs[i].e_v, vecs[i].e_h, vecs[i].e_cnt);
      end

      // PC wraps modulo 2^32 on the instance reset to FFFF_FFF8
      drive_step(0, 0, 0, 32'h0, 0);
      chk("wrap_pc", 0, w_pc, 32'hFFFF_FFF8);
      drive_step(1, 0, 0, 32'h0, 0);
      chk("wrap_pc", 1, w_pc, 32'hFFFF_FFFC);
      chk("wrap_ifidPC", 1, w_ifidPC, 32'hFFFF_FFF8);
      drive_step(1, 0, 0, 32'h0, 0);
      chk("wrap_pc", 2, w_pc, 32'h0000_0000);
      chk("wrap_ifidPC", 2, w_ifidPC, 32'hFFFF_FFFC);
      chk("wrap_instr", 2, w_ifidInstr, mem_word(32'hFFFF_FFFC));
      drive_step(1, 0, 0, 32'h0, 0);
      chk("wrap_pc", 3, w_pc, 32'h0000_0004);
      chk("wrap_cnt", 3, w_fetchCount, 32'd3);

      // Randomised run against the reference model
      drive_step(0, 0, 0, 32'h0, 0);
      m = model_next('{pc: 32'h0, ifpc: 32'h0, instr: 32'h13, cnt: 32'h0, v: 1'b0, h: 1'b0},
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) >= 2);
         s = ($urandom_range(0, 99) < 25);
         b = ($urandom_range(0, 99) < 10);
         h = ($urandom_range(0, 99) < 4);
         t = $urandom;
         drive_step(r, s, b, t, h);
         m = model_next(m, r, s, b, t, h);
         check_all(1000 + i, m.pc, m.ifpc, m.instr, m.v, m.h, m.cnt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
